// File: rtl/cnn_layer_engine.sv
// cnn_layer_engine
// Runs one complete CNN layer per start/done handshake:
//   multi-channel KxK convolution + bias -> requantisation (ReLU or
//   linear zero-point) -> POOL_SIZE x POOL_SIZE max/average pooling.
// One MAC window is time-shared: CONV evaluates one channel window per
// cycle, POOL produces one output pixel per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      layer start request, sampled only in IDLE
//   relu_en    1 = ReLU requant, 0 = linear requant with zero-point 2^(DW-1)
//   pool_mode  0 = max pooling, 1 = average pooling
//   out_shift  arithmetic right shift applied before clamping
//   bias       signed bias added once per conv output pixel
//   ifmap      unsigned input maps [IN_CH][IFMAP_SIZE][IFMAP_SIZE]
//   weights    signed kernels [IN_CH][KERNEL_SIZE][KERNEL_SIZE]
//   ofmap      unsigned pooled output [POOL_OUT][POOL_OUT], registered
//   busy       high in CONV, POOL and DONE
//   done       one-cycle pulse once ofmap is complete
module cnn_layer_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int IFMAP_SIZE  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IN_CH       = 2,
  parameter int POOL_SIZE   = 2,
  parameter int ACC_WIDTH   = 24,
  localparam int CONV_SIZE  = IFMAP_SIZE - KERNEL_SIZE + 1,
  localparam int POOL_OUT   = CONV_SIZE / POOL_SIZE,
  localparam int SHIFT_W    = $clog2(ACC_WIDTH)
) (
  input  logic                                                             clk,
  input  logic                                                             reset,
  input  logic                                                             start,
  input  logic                                                             relu_en,
  input  logic                                                             pool_mode,
  input  logic [SHIFT_W-1:0]                                               out_shift,
  input  logic signed [ACC_WIDTH-1:0]                                      bias,
  input  logic [IN_CH-1:0][IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][DATA_WIDTH-1:0]   ifmap,
  input  logic [IN_CH-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] weights,
  output logic [POOL_OUT-1:0][POOL_OUT-1:0][DATA_WIDTH-1:0]                  ofmap,
  output logic                                                             busy,
  output logic                                                             done
);

  localparam int CH_W  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int CS_W  = (CONV_SIZE > 1) ? $clog2(CONV_SIZE) : 1;
  localparam int PO_W  = (POOL_OUT > 1) ? $clog2(POOL_OUT) : 1;
  localparam int IF_W  = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
  localparam int SUM_W = DATA_WIDTH + $clog2(POOL_SIZE * POOL_SIZE);
  localparam int PROD_W = 2 * DATA_WIDTH + 1;

  localparam logic signed [ACC_WIDTH:0] ZERO_POINT = (ACC_WIDTH+1)'(2 ** (DATA_WIDTH - 1));
  localparam logic signed [ACC_WIDTH:0] MAX_OUT    = (ACC_WIDTH+1)'(2 ** DATA_WIDTH - 1);

  if (CONV_SIZE % POOL_SIZE != 0) begin : g_bad_pool
    $error("cnn_layer_engine: CONV_SIZE must be divisible by POOL_SIZE");
  end

  typedef enum logic [1:0] {IDLE, CONV, POOL, DONE} state_t;

  state_t state, state_next;

  logic [CH_W-1:0]                                          ch;
  logic [CS_W-1:0]                                          row, col;
  logic [PO_W-1:0]                                          pr, pc;
  logic signed [ACC_WIDTH-1:0]                              acc;
  logic [CONV_SIZE-1:0][CONV_SIZE-1:0][DATA_WIDTH-1:0]      conv_buf;

  logic signed [ACC_WIDTH-1:0] win_sum, acc_next, shifted;
  logic signed [ACC_WIDTH:0]   ext;
  logic [DATA_WIDTH-1:0]       conv_val, pool_val, pool_max;
  logic [SUM_W-1:0]            pool_sum;

  logic conv_last, pool_last;

  assign conv_last = (ch == CH_W'(IN_CH - 1)) && (col == CS_W'(CONV_SIZE - 1)) &&
                     (row == CS_W'(CONV_SIZE - 1));
  assign pool_last = (pc == PO_W'(POOL_OUT - 1)) && (pr == PO_W'(POOL_OUT - 1));

  // One channel's KxK window; the accumulator seeds from bias on channel 0
  always_comb begin : p_mac
    logic [IF_W-1:0]          pix_r, pix_c;
    logic signed [PROD_W-1:0] prod;
    win_sum = '0;
    pix_r   = '0;
    pix_c   = '0;
    prod    = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
        pix_r   = IF_W'(row) + IF_W'(i);
        pix_c   = IF_W'(col) + IF_W'(j);
        prod    = $signed({1'b0, ifmap[ch][pix_r][pix_c]}) * $signed(weights[ch][i][j]);
        win_sum = win_sum + ACC_WIDTH'(prod);
      end
    end
    acc_next = ((ch == '0) ? bias : acc) + win_sum;
  end

  // Requantisation: shift, optional zero-point offset, clamp to [0, 2^DW-1]
  always_comb begin : p_requant
    shifted = acc_next >>> out_shift;
    ext     = (ACC_WIDTH+1)'(shifted);
    if (!relu_en) ext = ext + ZERO_POINT;
    if (ext[ACC_WIDTH])     conv_val = '0;
    else if (ext > MAX_OUT) conv_val = '1;
    else                    conv_val = ext[DATA_WIDTH-1:0];
  end

  // Pooling window at (pr, pc) of the conv buffer
  always_comb begin : p_pool
    logic [CS_W-1:0] r, c;
    pool_max = '0;
    pool_sum = '0;
    r = '0;
    c = '0;
    for (int i = 0; i < POOL_SIZE; i++) begin
      for (int j = 0; j < POOL_SIZE; j++) begin
        r = CS_W'(int'(pr) * POOL_SIZE + i);
        c = CS_W'(int'(pc) * POOL_SIZE + j);
        pool_sum = pool_sum + SUM_W'(conv_buf[r][c]);
        if (conv_buf[r][c] > pool_max) pool_max = conv_buf[r][c];
      end
    end
    pool_val = pool_mode ? DATA_WIDTH'(pool_sum / SUM_W'(POOL_SIZE * POOL_SIZE)) : pool_max;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (conv_last) state_next = POOL;
      POOL:    if (pool_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: channel-innermost conv sweep, then raster pooling sweep
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch       <= '0;
      row      <= '0;
      col      <= '0;
      pr       <= '0;
      pc       <= '0;
      acc      <= '0;
      conv_buf <= '0;
      ofmap    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ch  <= '0;
            row <= '0;
            col <= '0;
            pr  <= '0;
            pc  <= '0;
            acc <= '0;
          end
        end
        CONV: begin
          acc <= acc_next;
          if (ch == CH_W'(IN_CH - 1)) begin
            conv_buf[row][col] <= conv_val;
            ch <= '0;
            if (col == CS_W'(CONV_SIZE - 1)) begin
              col <= '0;
              row <= (row == CS_W'(CONV_SIZE - 1)) ? '0 : row + CS_W'(1);
            end else begin
              col <= col + CS_W'(1);
            end
          end else begin
            ch <= ch + CH_W'(1);
          end
        end
        POOL: begin
          ofmap[pr][pc] <= pool_val;
          if (pc == PO_W'(POOL_OUT - 1)) begin
            pc <= '0;
            pr <= (pr == PO_W'(POOL_OUT - 1)) ? '0 : pr + PO_W'(1);
          end else begin
            pc <= pc + PO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_engine.sv
// tb_cnn_layer_engine
// Directed bench for cnn_layer_engine with default parameters: drives
// uniform and sparse ifmap/weight patterns, checks handshake timing and
// every ofmap pixel against hand-computed values.
module tb_cnn_layer_engine;

  logic                          clk;
  logic                          reset;
  logic                          start;
  logic                          relu_en;
  logic                          pool_mode;
  logic [4:0]                    out_shift;
  logic signed [23:0]            bias;
  logic [1:0][7:0][7:0][7:0]     ifmap;
  logic [1:0][2:0][2:0][7:0]     weights;
  logic [2:0][2:0][7:0]          ofmap;
  logic                          busy;
  logic                          done;

  int checks;
  int failures;

  cnn_layer_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .relu_en   (relu_en),
    .pool_mode (pool_mode),
    .out_shift (out_shift),
    .bias      (bias),
    .ifmap     (ifmap),
    .weights   (weights),
    .ofmap     (ofmap),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a handshake never completes
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Uniform per-channel pixels and weights plus the control inputs
  task automatic applyStimulus(input int pix0, input int pix1, input int wgt0, input int wgt1,
                               input int b, input int sh, input bit relu, input bit pmode);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ifmap[0][r][c] = 8'(pix0);
        ifmap[1][r][c] = 8'(pix1);
      end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        weights[0][r][c] = 8'(wgt0);
        weights[1][r][c] = 8'(wgt1);
      end
    bias      = 24'(b);
    out_shift = 5'(sh);
    relu_en   = relu;
    pool_mode = pmode;
  endtask

  // Starts a layer, optionally re-pulses start at CONV cycle poke_at,
  // and checks latency, busy length and the single-cycle done pulse
  task automatic runLayer(input string tag, input int poke_at);
    int lat;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      start = (lat == poke_at);
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, lat, 81);
    checkOutput({tag, "_busy_cycles"}, busy_cnt, 82);
    @(negedge clk);
    checkOutput({tag, "_done_pulse_end"}, int'(done), 0);
    checkOutput({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  // All pixels equal exp_all except ofmap[1][1], which must equal exp_center
  task automatic checkOfmap(input string tag, input int exp_all, input int exp_center);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        checkOutput($sformatf("%s_ofmap[%0d][%0d]", tag, r, c), int'(ofmap[r][c]),
                    (r == 1 && c == 1) ? exp_center : exp_all);
  endtask

  initial begin
    int done_seen;
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    reset    = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOfmap("reset", 0, 0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] uniform relu max");
    applyStimulus(1, 1, 1, 1, 0, 0, 1'b1, 1'b0);
    runLayer("uniform", -1);
    checkOfmap("uniform", 18, 18);

    $display("[TB] negative weights");
    applyStimulus(1, 1, -1, -1, 0, 0, 1'b1, 1'b0);
    runLayer("neg_relu", -1);
    checkOfmap("neg_relu", 0, 0);
    applyStimulus(1, 1, -1, -1, 0, 0, 1'b0, 1'b0);
    runLayer("neg_linear", -1);
    checkOfmap("neg_linear", 110, 110);

    $display("[TB] saturation and shift");
    applyStimulus(255, 255, 127, 127, 0, 0, 1'b1, 1'b0);
    runLayer("saturate", -1);
    checkOfmap("saturate", 255, 255);
    applyStimulus(0, 0, 0, 0, -100, 2, 1'b0, 1'b0);
    runLayer("bias_shift", -1);
    checkOfmap("bias_shift", 103, 103);

    // ch0: 9*1*1, ch1: 9*2*3, bias 5 -> 68 >>> 1 = 34
    $display("[TB] distinct channels");
    applyStimulus(1, 2, 1, 3, 5, 1, 1'b1, 1'b0);
    runLayer("channels", -1);
    checkOfmap("channels", 34, 34);

    $display("[TB] pool modes");
    applyStimulus(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    ifmap[0][4][4]   = 8'd200;
    weights[0][1][1] = 8'd1;
    runLayer("pool_max", -1);
    checkOfmap("pool_max", 0, 200);
    pool_mode = 1'b1;
    runLayer("pool_avg", -1);
    checkOfmap("pool_avg", 0, 50);

    $display("[TB] start while busy");
    applyStimulus(1, 1, 1, 1, 0, 0, 1'b1, 1'b0);
    runLayer("busy_start", 10);
    checkOfmap("busy_start", 18, 18);

    $display("[TB] reset during conv");
    applyStimulus(2, 2, 1, 1, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOfmap("abort", 0, 0);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);
    runLayer("after_abort", -1);
    checkOfmap("after_abort", 36, 36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
